// File: rtl/bnn_pkg.sv
// Shared types, default layer geometry and width helpers for the BNN layer sequencer.
package bnn_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        SEND    = 2'd3
    } state_e;

    localparam int DEF_IN_BITS = 64;
    localparam int DEF_NEURONS = 16;
    localparam int DEF_THRESH  = 32;

    // Wide enough to hold a popcount of 0..in_bits without wrapping.
    function automatic int acc_width(input int in_bits);
        return $clog2(in_bits + 1);
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bnn_sequencer_if.sv
// Byte-stream, weight-ROM and status signals of the BNN sequencer; master is the sequencer side.
interface bnn_sequencer_if #(
    parameter int ADDR_W = 7
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [ADDR_W-1:0] w_addr;
    logic              w_en;
    logic [7:0]        w_data;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;
    logic              done;

    modport master (
        input  rx_data, rx_valid, w_data, tx_ready,
        output rx_ready, w_addr, w_en, tx_data, tx_valid, busy, done
    );

    modport slave (
        output rx_data, rx_valid, w_data, tx_ready,
        input  rx_ready, w_addr, w_en, tx_data, tx_valid, busy, done
    );
endinterface

// File: rtl/xnor_popcount8.sv
// Combinational count of matching bit positions between two bytes (0..8); no latency, no flow control.
module xnor_popcount8 (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [3:0] cnt_o
);
    logic [7:0] match;

    always_comb begin
        match = ~(a_i ^ b_i);
        cnt_o = '0;
        for (int i = 0; i < 8; i++) begin
            cnt_o = cnt_o + {3'b000, match[i]};
        end
    end
endmodule

// File: rtl/bnn_sequencer.sv
// One BNN layer: load activation bytes, sweep weight ROM with XNOR-popcount, stream packed result bytes.
// Sender stalls via rx_ready outside IDLE/LOAD; result bytes hold on tx until tx_ready; ROM read latency is 1 cycle.
module bnn_sequencer
    import bnn_pkg::*;
#(
    parameter int IN_BITS = DEF_IN_BITS,
    parameter int NEURONS = DEF_NEURONS,
    parameter int THRESH  = DEF_THRESH
) (
    input  logic            clk,
    input  logic            rst_n,
    bnn_sequencer_if.master bus
);
    localparam int NB     = IN_BITS / 8;
    localparam int NO     = NEURONS / 8;
    localparam int ADDR_W = cnt_width(NEURONS * NB);
    localparam int ACC_W  = acc_width(IN_BITS);
    localparam int BC_W   = cnt_width(NB);
    localparam int N_W    = cnt_width(NEURONS);
    localparam int TX_W   = cnt_width(NO);
    localparam logic [31:0] THR = 32'(THRESH);

    state_e state_q, state_d;

    logic [BC_W-1:0]        byte_cnt_q;
    logic [NB-1:0][7:0]     act_q;
    logic [ADDR_W-1:0]      w_addr_q;
    logic [BC_W-1:0]        iss_chunk_q;
    logic [N_W-1:0]         iss_neur_q;
    logic                   issue_done_q;
    logic                   rd_vld_q;
    logic [BC_W-1:0]        rd_chunk_q;
    logic [N_W-1:0]         rd_neur_q;
    logic [ACC_W-1:0]       acc_q;
    logic [NEURONS-1:0]     result_q;
    logic [TX_W-1:0]        tx_idx_q;
    logic                   done_q;

    logic             rx_ready, w_en, tx_valid, busy;
    logic             rx_fire, tx_fire, load_last, rd_last_chunk, compute_end, send_last;
    logic [3:0]       pc;
    logic [ACC_W-1:0] acc_sum;
    logic [7:0]       tx_byte;

    assign rx_fire       = bus.rx_valid && rx_ready;
    assign tx_fire       = tx_valid && bus.tx_ready;
    assign load_last     = (state_q == LOAD) && rx_fire && (byte_cnt_q == BC_W'(NB - 1));
    assign rd_last_chunk = rd_vld_q && (rd_chunk_q == BC_W'(NB - 1));
    assign compute_end   = rd_last_chunk && (rd_neur_q == N_W'(NEURONS - 1));
    assign send_last     = tx_fire && (tx_idx_q == TX_W'(NO - 1));

    xnor_popcount8 u_xpc (
        .a_i   (bus.w_data),
        .b_i   (act_q[rd_chunk_q]),
        .cnt_o (pc)
    );

    assign acc_sum = acc_q + ACC_W'(pc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rx_fire)     state_d = LOAD;
            LOAD:    if (load_last)   state_d = COMPUTE;
            COMPUTE: if (compute_end) state_d = SEND;
            SEND:    if (send_last)   state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    always_comb begin
        rx_ready = 1'b0;
        w_en     = 1'b0;
        tx_valid = 1'b0;
        busy     = 1'b1;
        case (state_q)
            IDLE:    begin rx_ready = 1'b1; busy = 1'b0; end
            LOAD:    rx_ready = 1'b1;
            COMPUTE: w_en = !issue_done_q;
            SEND:    tx_valid = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    always_comb begin
        tx_byte = '0;
        for (int j = 0; j < NO; j++) begin
            if (tx_idx_q == TX_W'(j)) tx_byte = result_q[8*j +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q   <= '0;
            act_q        <= '0;
            w_addr_q     <= '0;
            iss_chunk_q  <= '0;
            iss_neur_q   <= '0;
            issue_done_q <= 1'b0;
            rd_vld_q     <= 1'b0;
            rd_chunk_q   <= '0;
            rd_neur_q    <= '0;
            acc_q        <= '0;
            result_q     <= '0;
            tx_idx_q     <= '0;
            done_q       <= 1'b0;
        end else begin
            done_q <= send_last;

            // byte_cnt_q wraps to 0 on the last byte so IDLE always writes byte 0
            if (rx_fire) begin
                act_q[byte_cnt_q] <= bus.rx_data;
                byte_cnt_q <= load_last ? '0 : byte_cnt_q + 1'b1;
            end

            if (load_last) begin
                w_addr_q     <= '0;
                iss_chunk_q  <= '0;
                iss_neur_q   <= '0;
                issue_done_q <= 1'b0;
            end else if (w_en) begin
                if (w_addr_q == ADDR_W'(NEURONS * NB - 1)) begin
                    issue_done_q <= 1'b1;
                end else begin
                    w_addr_q <= w_addr_q + 1'b1;
                end
                if (iss_chunk_q == BC_W'(NB - 1)) begin
                    iss_chunk_q <= '0;
                    iss_neur_q  <= iss_neur_q + 1'b1;
                end else begin
                    iss_chunk_q <= iss_chunk_q + 1'b1;
                end
            end

            // Tags travel with the read so the returned byte knows its chunk and neuron
            rd_vld_q   <= w_en;
            rd_chunk_q <= iss_chunk_q;
            rd_neur_q  <= iss_neur_q;

            if (rd_vld_q) begin
                if (rd_last_chunk) begin
                    result_q[rd_neur_q] <= (32'(acc_sum) >= THR);
                    acc_q <= '0;
                end else begin
                    acc_q <= acc_sum;
                end
            end

            if (tx_fire) begin
                tx_idx_q <= send_last ? '0 : tx_idx_q + 1'b1;
            end
        end
    end

    assign bus.rx_ready = rx_ready;
    assign bus.w_addr   = w_addr_q;
    assign bus.w_en     = w_en;
    assign bus.tx_data  = tx_byte;
    assign bus.tx_valid = tx_valid;
    assign bus.busy     = busy;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_bnn_sequencer.sv
// Directed and golden-model checks for bnn_sequencer with the default 64-bit, 16-neuron geometry.
module tb_bnn_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bnn_sequencer_if #(.ADDR_W(7)) bus ();

    bnn_sequencer #(
        .IN_BITS (64),
        .NEURONS (16),
        .THRESH  (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] rom [128];
    always_ff @(posedge clk) begin
        if (bus.w_en) bus.w_data <= rom[bus.w_addr];
    end

    int n_chk = 0;
    int n_fail = 0;
    int done_total = 0;
    always @(negedge clk) begin
        if (bus.done) done_total++;
    end

    typedef struct {
        logic [7:0]  act;
        logic [7:0]  rom_def;
        int          n0;
        logic [63:0] w0;
        int          n1;
        logic [63:0] w1;
        logic [15:0] exp;
        bit          tog;
        int          stall;
        string       nm;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic load_rom(input logic [7:0] def, input int n0, input logic [63:0] w0,
                            input int n1, input logic [63:0] w1);
        for (int a = 0; a < 128; a++) rom[a] = def;
        if (n0 >= 0) for (int c = 0; c < 8; c++) rom[n0*8 + c] = w0[8*c +: 8];
        if (n1 >= 0) for (int c = 0; c < 8; c++) rom[n1*8 + c] = w1[8*c +: 8];
    endtask

    function automatic logic [15:0] golden(input logic [63:0] a);
        logic [15:0] r;
        int pc;
        r = '0;
        for (int n = 0; n < 16; n++) begin
            pc = 0;
            for (int i = 0; i < 64; i++) begin
                if (rom[n*8 + i/8][i%8] == a[i]) pc++;
            end
            r[n] = (pc >= 32);
        end
        return r;
    endfunction

    task automatic send_byte(input logic [7:0] b, output int tries, output bit acc);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tries = 0;
        acc   = 1'b0;
        while (!acc && tries < 200) begin
            acc = bus.rx_ready;
            tries++;
            @(posedge clk);
            #1;
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic load_act(input logic [63:0] act, input bit tog, input string nm);
        int  tries;
        bit  acc;
        for (int k = 0; k < 8; k++) begin
            send_byte(act[8*k +: 8], tries, acc);
            if (k == 0) check({nm, "_first_byte_tries"}, tries, 1);
            else if (!acc) check({nm, "_byte_accepted"}, 0, 1);
            if (tog && k < 7) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    // Returns at the falling edge of the done cycle.
    task automatic do_run(input logic [63:0] act, input logic [15:0] exp, input bit tog,
                          input int stall, input string nm);
        int cyc, ens, aerr, serr, xfer;
        logic [15:0] got;
        logic [7:0]  hold;
        load_act(act, tog, nm);
        cyc = 0; ens = 0; aerr = 0; serr = 0; xfer = 0; got = '0;
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            if (bus.tx_valid) break;
            cyc++;
            if (bus.w_en) begin
                if (bus.w_addr !== 7'(ens)) aerr++;
                ens++;
            end
        end
        check({nm, "_compute_cycles"}, cyc, 129);
        check({nm, "_w_en_cycles"}, ens, 128);
        check({nm, "_addr_order_errs"}, aerr, 0);
        if (stall > 0) begin
            hold = bus.tx_data;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                if (!bus.tx_valid || bus.tx_data !== hold) serr++;
            end
            check({nm, "_stall_hold_errs"}, serr, 0);
        end
        bus.tx_ready = 1'b1;
        for (int t = 0; t < 50 && !bus.done; t++) begin
            if (bus.tx_valid) begin
                if (xfer < 2) got[8*xfer +: 8] = bus.tx_data;
                xfer++;
            end
            @(negedge clk);
        end
        bus.tx_ready = 1'b0;
        check({nm, "_transfers"}, xfer, 2);
        check({nm, "_done_seen"}, bus.done, 1);
        check({nm, "_busy_in_done"}, bus.busy, 0);
        check({nm, "_result"}, got, exp);
    endtask

    initial begin
        logic [63:0] ract;
        logic [15:0] rexp;

        vecs[0] = '{8'hFF, 8'hFF, -1, 64'h0, -1, 64'h0, 16'hFFFF, 1'b0, 0, "all_ones"};
        vecs[1] = '{8'h00, 8'hFF, -1, 64'h0, -1, 64'h0, 16'h0000, 1'b1, 0, "all_mismatch"};
        vecs[2] = '{8'h00, 8'hFF, 3, 64'h0, -1, 64'h0, 16'h0008, 1'b0, 5, "neuron3_match"};
        vecs[3] = '{8'hFF, 8'h00, 0, 64'h00000000FFFFFFFF, 1, 64'h000000007FFFFFFF,
                    16'h0001, 1'b1, 5, "thresh_edge"};
        vecs[4] = '{8'hAA, 8'h55, 9, 64'hAAAAAAAAAAAAAAAA, 1, 64'hAAAAAAAA55555555,
                    16'h0202, 1'b0, 0, "mixed"};

        bus.rx_data  = '0;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_rx_ready", bus.rx_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_w_en", bus.w_en, 0);
        check("rst_tx_valid", bus.tx_valid, 0);
        check("rst_done", bus.done, 0);
        check("rst_w_addr", bus.w_addr, 0);
        check("rst_tx_data", bus.tx_data, 0);

        for (int v = 0; v < 5; v++) begin
            load_rom(vecs[v].rom_def, vecs[v].n0, vecs[v].w0, vecs[v].n1, vecs[v].w1);
            do_run({8{vecs[v].act}}, vecs[v].exp, vecs[v].tog, vecs[v].stall, vecs[v].nm);
        end

        // Abort a run part-way through COMPUTE, then confirm a clean follow-up run.
        load_rom(8'hFF, -1, 64'h0, -1, 64'h0);
        load_act({8{8'hFF}}, 1'b0, "rst_mid");
        repeat (40) @(negedge clk);
        check("rst_mid_w_en_active", bus.w_en, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_w_en", bus.w_en, 0);
        check("rst_mid_tx_valid", bus.tx_valid, 0);
        check("rst_mid_rx_ready", bus.rx_ready, 1);
        check("rst_mid_w_addr", bus.w_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load_rom(8'hFF, 5, 64'h0, -1, 64'h0);
        do_run(64'h0, 16'h0020, 1'b0, 0, "post_rst");

        for (int r = 0; r < 20; r++) begin
            for (int a = 0; a < 128; a++) rom[a] = 8'($urandom_range(0, 255));
            ract = {$urandom, $urandom};
            rexp = golden(ract);
            do_run(ract, rexp, r[0], (r % 3 == 0) ? 2 : 0, $sformatf("rand%0d", r));
        end

        @(negedge clk);
        check("done_pulses", done_total, 26);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bnn_sequencer.md
# bnn_sequencer

Sequencer for the binary neural network layer. Accepts an input activation vector as a byte stream from the UART receive path and sweeps every neuron's weights from an external weight ROM. Each neuron's XNOR-popcount is compared against a fixed threshold. The packed output bits are returned as a byte stream to the UART transmit path. It sits between the UART front end inside `controller` and the weight storage, and owns all sequencing of one layer evaluation.

## Interface
Parameters:
- `IN_BITS`, 64, activation vector width; multiple of 8.
- `NEURONS`, 16, neurons per layer; multiple of 8.
- `THRESH`, 32, output bit is 1 when popcount ≥ THRESH.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: byte is accepted when `rx_valid` and `rx_ready` are both high.
- `w_addr` out clog2(NEURONS·IN_BITS/8): weight ROM byte address.
- `w_en` out 1: ROM read strobe.
- `w_data` in 8: ROM data, valid exactly 1 cycle after `w_en`.
- `tx_data` out 8: result byte.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: transfer occurs when `tx_valid` and `tx_ready` are both high.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle pulse after the last result byte is transferred.

## Operation
- States: IDLE → LOAD → COMPUTE → SEND → IDLE.
- **IDLE**
  - `rx_ready` = 1.
  - The first accepted byte becomes activation bits [7:0] and moves the FSM to LOAD. The byte counter is set to 1.
- **LOAD**
  - `rx_ready` = 1.
  - Accepted byte k fills activation bits [8k+7:8k].
  - After byte IN_BITS/8−1 is accepted, the FSM moves to COMPUTE.
  - `rx_ready` = 0 in all other states; bytes are not dropped, the sender stalls.
- **COMPUTE**
  - For neuron n (0..NEURONS−1) and chunk c (0..IN_BITS/8−1), issue `w_addr` = n·IN_BITS/8 + c with `w_en` = 1, one address per cycle, with no gaps.
  - On each returned byte, accumulate popcount(~(w_data ^ act[8c+7:8c])).
  - The accumulator is clog2(IN_BITS+1) bits wide (7 for the defaults) and never saturates or wraps.
  - After the last chunk of neuron n returns, `result[n]` = (acc ≥ THRESH) and the accumulator clears.
  - The first chunk of neuron n+1 accumulates in the same cycle as that clear, starting from 0.
- **SEND**
  - Present `result[8j+7:8j]` for j = 0..NEURONS/8−1, in order. Neuron 0 is bit 0 of byte 0.
  - `tx_valid` and `tx_data` stay stable until accepted.
  - After the last byte is transferred: IDLE, with `done` = 1 for one cycle.
- The activation register is not cleared between runs; every run overwrites all bytes.

## Timing
- Reset values:
  - state IDLE.
  - `rx_ready` = 1.
  - `tx_valid`, `w_en`, `busy`, `done` = 0.
  - `w_addr`, `tx_data`, accumulator, byte counters, activation and result registers all 0.
- LOAD takes IN_BITS/8 accepted bytes; it is unbounded if `rx_valid` stalls.
- COMPUTE takes exactly NEURONS·IN_BITS/8 + 1 cycles: address issue plus one drain cycle. For the defaults this is 129 cycles.
- The first `tx_valid` is asserted in the cycle after COMPUTE ends.
- With `tx_ready` held high, SEND takes NEURONS/8 cycles.
- The `done` pulse occurs the cycle after the final handshake. `busy` falls in that same cycle.
- A new `rx_valid` in the `done` cycle is accepted; IDLE is ready.
- `w_en` is low outside COMPUTE. `w_addr` holds its last value.
- Reset mid-operation:
  - Asynchronous return to IDLE; all partial results are discarded.
  - Outputs take their reset values immediately.
  - No `done` pulse.

## Structure
- Shared package `bnn_pkg` holds:
  - state enum (IDLE, LOAD, COMPUTE, SEND).
  - default IN_BITS, NEURONS, THRESH.
  - the accumulator width function.
- Sub-module `xnor_popcount8`: combinational 8-bit XNOR followed by popcount, giving a 4-bit result. It is instantiated once in the accumulate stage.

## Test plan
- **All ones:** activation all 0xFF, ROM all 0xFF → every popcount = 64 → tx bytes 0xFF, 0xFF; `done` once; COMPUTE lasts 129 cycles.
- **Alternating match:** activation all 0x00, ROM all 0xFF → popcounts 0 → tx 0x00, 0x00. Then program neuron 3 weights = 0x00 → popcount 64 → tx 0x08, 0x00.
- **Threshold boundary:** activation all 0xFF.
  - Neuron 0 weights with exactly 32 ones → bit 0 = 1.
  - Neuron 1 weights with 31 ones → bit 1 = 0.
  - Expected first byte 0x01.
- **Backpressure:**
  - `rx_valid` toggled 1/0 each cycle → 8 bytes load correctly.
  - `tx_ready` held low 5 cycles → `tx_valid` = 1 and `tx_data` stable throughout; one transfer per byte.
- **Reset mid-COMPUTE:** assert `rst_n` = 0 at cycle 40 of COMPUTE → `busy`, `w_en`, `tx_valid` = 0 immediately. Then a full new run produces the correct result with no stale bits.
- **Back-to-back runs:** second run's first byte presented in the `done` cycle → accepted. Result matches a golden model for random activations and weights over 20 runs.
